decoder38_scan_ctrl: RTL
========================

Name: decoder38_scan_ctrl

Overview:
Time-multiplexed scan controller that sequences a 3-to-8 select across up to eight outputs, such as display digits or LED rows.
- Visits only the positions enabled in a mask, in ascending order, wrapping around.
- Holds each position for a programmable dwell, with a fixed blanking gap between positions.
- Drives an active-low one-hot output that is 8'hFF while blanked or idle.
- Sits between the decoder38 family and the display/LED pins; decode is registered inside the block.

Parameters:
CNT_W, 16, width of the dwell input and the internal down-counter
BLANK_CYC, 4, cycles of all-off blanking before each position (legal range 1..2**CNT_W-1)

Ports:
i_clk  input  1  system clock; all state changes on the rising edge
i_rst  input  1  synchronous, active-high reset
i_en  input  1  scan enable; level-sensitive
i_mask  input  8  bit k=1 means position k is scanned
i_dwell  input  CNT_W  cycles per position; 0 is treated as 1
o_sel  output  3  current position index
o_y  output  8  active-low one-hot; ~(1<<o_sel) in DRIVE, 8'hFF otherwise
o_blank  output  1  1 when o_y == 8'hFF
o_frame  output  1  one-cycle pulse when the scan wraps

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst. All outputs are registered.
- Reset values: state=IDLE, o_sel=0, o_y=8'hFF, o_blank=1, o_frame=0, cnt=0. Reset has priority over every other input, including mid-DRIVE.
- Counters:
  - cnt is a down-counter.
  - On entering BLANK, load BLANK_CYC-1.
  - On entering DRIVE, load max(i_dwell,1)-1, with i_dwell sampled on the entering edge.
  - i_dwell changes take effect at the next DRIVE entry only.
- next_pos(sel, mask): lowest set bit of mask strictly above sel; if none, lowest set bit overall. wrap=1 when the result is <= sel.
- IDLE:
  - o_y=FF.
  - If i_en && i_mask!=0: go to BLANK with o_sel = lowest set bit of i_mask.
  - Never pulses o_frame.
- BLANK:
  - o_y=FF.
  - When cnt==0: go to DRIVE; on the same edge o_y <= ~(1<<o_sel) and o_blank <= 0.
  - Otherwise cnt decrements.
- DRIVE:
  - o_y is held.
  - When cnt==0: go to BLANK, o_sel <= next_pos(o_sel, i_mask), o_frame <= wrap; on the same edge o_y <= FF and o_blank <= 1.
  - A single-bit mask revisits the same position and pulses o_frame on every visit.
- Mask edits:
  - If i_mask[o_sel] clears during DRIVE, terminate early: behave as cnt==0 on that edge.
  - i_mask==0 in any state: next edge goes to IDLE.
- Enable:
  - i_en low in any state: next edge goes to IDLE with o_y=FF.
  - Re-enable restarts at the lowest enabled position. Position is not resumed.
- Latency: i_en sampled high at edge 0 → BLANK at edge 1 → first o_y low at edge 1+BLANK_CYC.
- Steady-state frame period: N*(BLANK_CYC+max(dwell,1)), where N=popcount(mask).
- o_frame is 0 on every edge except the wrap transition.

Decomposition:
- Package decoder38_pkg:
  - state enum {IDLE, BLANK, DRIVE}
  - function onehot_n(sel) returning ~(8'b1<<sel), shared with other decoder38 blocks
  - constant ALL_OFF=8'hFF
- Sub-module decoder38_next_pos: combinational rotate-priority finder, inputs sel[2:0] and mask[7:0], outputs nxt[2:0], wrap, any. Instantiated once.

Test Plan:
- Reset check: assert i_rst with i_en=1 and mask=FF for 3 cycles → o_y=FF, o_sel=0, o_blank=1, o_frame=0. Reset asserted mid-DRIVE → o_y=FF on the next edge.
- Full mask, mask=FF, dwell=3, BLANK_CYC=4:
  - o_y sequence FF×4, FE×3, FF×4, FD×3, … 7F×3.
  - o_frame pulses on the 7→0 edge.
  - Frame period 56 cycles.
- Sparse mask, mask=8'b1010_0100, dwell=1: o_sel visits 2,5,7,2,…; o_frame only on 7→2; o_y values FB, DF, 7F.
- Single bit, mask=8'h10, dwell=2: o_y alternates EF×2 / FF×4; o_frame pulses every visit; o_sel constant 4.
- Enable drop: deassert i_en mid-DRIVE at sel=5 → next edge o_y=FF, state IDLE. Re-enable → BLANK, then DRIVE at lowest mask bit.
- Edge cases:
  - dwell=0 → each position driven exactly 1 cycle.
  - Clear i_mask[o_sel] mid-DRIVE → next edge blanks and advances.
  - mask→0 → IDLE, o_blank=1.

Source files
------------

// File: rtl/decoder38_pkg.sv
// -----------------------------------------------------------------------------
// decoder38_pkg
// Shared types and helpers for the decoder38 family of blocks.
//   state_t   : scan controller state encoding (IDLE, BLANK, DRIVE)
//   ALL_OFF   : active-low 8-line output with every line inactive
//   onehot_n  : active-low one-hot decode of a 3-bit select
// -----------------------------------------------------------------------------
package decoder38_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam logic [7:0] ALL_OFF = 8'hFF;

    // Active-low one-hot: exactly line 'sel' is pulled low.
    function automatic logic [7:0] onehot_n(input logic [2:0] sel);
        return ~(8'b0000_0001 << sel);
    endfunction

endpackage : decoder38_pkg

// File: rtl/decoder38_next_pos.sv
// -----------------------------------------------------------------------------
// decoder38_next_pos
// Combinational rotate-priority finder. Returns the lowest set mask bit
// strictly above 'sel'; when there is none, the lowest set bit overall.
// Ports:
//   i_sel  [2:0] : current position
//   i_mask [7:0] : enabled positions
//   o_nxt  [2:0] : next enabled position (0 when mask is empty)
//   o_wrap       : next position is at or below the current one
//   o_any        : mask has at least one bit set
// -----------------------------------------------------------------------------
module decoder38_next_pos (
    input  logic [2:0] i_sel,
    input  logic [7:0] i_mask,
    output logic [2:0] o_nxt,
    output logic       o_wrap,
    output logic       o_any
);

    logic [2:0] w_above;
    logic       w_found_above;
    logic [2:0] w_lowest;

    // Scan from the top down so the last match seen is the lowest index.
    always_comb begin
        w_above       = 3'd0;
        w_found_above = 1'b0;
        w_lowest      = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (i_mask[i]) begin
                w_lowest = 3'(i);
                if (3'(i) > i_sel) begin
                    w_above       = 3'(i);
                    w_found_above = 1'b1;
                end else begin
                    w_found_above = w_found_above;
                end
            end else begin
                w_lowest = w_lowest;
            end
        end
    end

    // Select above-match first, otherwise wrap to the lowest set bit.
    always_comb begin
        o_any = |i_mask;
        if (w_found_above) begin
            o_nxt = w_above;
        end else begin
            o_nxt = w_lowest;
        end
        // A single-bit mask returns to itself, which also counts as a wrap.
        if (o_any && (o_nxt <= i_sel)) begin
            o_wrap = 1'b1;
        end else begin
            o_wrap = 1'b0;
        end
    end

endmodule : decoder38_next_pos

// File: rtl/decoder38_scan_ctrl.sv
// -----------------------------------------------------------------------------
// decoder38_scan_ctrl
// Time-multiplexed scan controller. Steps through the enabled positions of
// i_mask in ascending order, wrapping around; each position is preceded by
// BLANK_CYC all-off cycles and then driven for max(i_dwell,1) cycles.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst    : synchronous active-high reset
//   i_en     : scan enable (level)
//   i_mask   : bit k enables position k
//   i_dwell  : drive cycles per position, 0 behaves as 1
//   o_sel    : current position index
//   o_y      : active-low one-hot output, 8'hFF while blanked/idle
//   o_blank  : high whenever o_y is 8'hFF
//   o_frame  : one-cycle pulse on the wrap transition
// -----------------------------------------------------------------------------
module decoder38_scan_ctrl
    import decoder38_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int BLANK_CYC = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [7:0]       i_mask,
    input  logic [CNT_W-1:0] i_dwell,
    output logic [2:0]       o_sel,
    output logic [7:0]       o_y,
    output logic             o_blank,
    output logic             o_frame
);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_sel;
    logic [7:0]       r_y;
    logic             r_blank;
    logic             r_frame;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_sel_nxt;
    logic [7:0]       w_y_nxt;
    logic             w_blank_nxt;
    logic             w_frame_nxt;

    logic [2:0]       w_np_sel;
    logic [2:0]       w_np_nxt;
    logic             w_np_wrap;
    logic             w_np_any;
    logic [CNT_W-1:0] w_dwell_load;

    // From IDLE, searching above position 7 finds nothing, so the finder
    // falls back to the lowest set bit: one instance serves both cases.
    assign w_np_sel = (r_state == IDLE) ? 3'd7 : r_sel;

    decoder38_next_pos u_next_pos (
        .i_sel  (w_np_sel),
        .i_mask (i_mask),
        .o_nxt  (w_np_nxt),
        .o_wrap (w_np_wrap),
        .o_any  (w_np_any)
    );

    // Dwell of zero is promoted to a single drive cycle.
    always_comb begin
        if (i_dwell == CNT_ZERO) begin
            w_dwell_load = CNT_ZERO;
        end else begin
            w_dwell_load = i_dwell - CNT_ONE;
        end
    end

    // Next-state and next-output logic for the scan FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_y_nxt     = r_y;
        w_blank_nxt = r_blank;
        w_frame_nxt = 1'b0;

        if (!i_en || !w_np_any) begin
            // Disable or empty mask abandons the scan from any state.
            w_state_nxt = IDLE;
            w_cnt_nxt   = CNT_ZERO;
            w_y_nxt     = ALL_OFF;
            w_blank_nxt = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = BLANK;
                    w_sel_nxt   = w_np_nxt;
                    w_cnt_nxt   = BLANK_LOAD;
                    w_y_nxt     = ALL_OFF;
                    w_blank_nxt = 1'b1;
                end
                BLANK: begin
                    if (r_cnt == CNT_ZERO) begin
                        w_state_nxt = DRIVE;
                        w_cnt_nxt   = w_dwell_load;
                        w_y_nxt     = onehot_n(r_sel);
                        w_blank_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt   = r_cnt - CNT_ONE;
                    end
                end
                DRIVE: begin
                    // Losing the current mask bit ends the dwell immediately.
                    if ((r_cnt == CNT_ZERO) || !i_mask[r_sel]) begin
                        w_state_nxt = BLANK;
                        w_sel_nxt   = w_np_nxt;
                        w_frame_nxt = w_np_wrap;
                        w_cnt_nxt   = BLANK_LOAD;
                        w_y_nxt     = ALL_OFF;
                        w_blank_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                    w_y_nxt     = ALL_OFF;
                    w_blank_nxt = 1'b1;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= CNT_ZERO;
            r_sel   <= 3'd0;
            r_y     <= ALL_OFF;
            r_blank <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_y     <= w_y_nxt;
            r_blank <= w_blank_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    assign o_sel   = r_sel;
    assign o_y     = r_y;
    assign o_blank = r_blank;
    assign o_frame = r_frame;

endmodule : decoder38_scan_ctrl
